// File: rtl/pr_reconfig_ctrl.sv
// pr_reconfig_ctrl: sequences one partial-reconfiguration load (decouple, ICAP stream, flush, RM reset, recouple).
module pr_reconfig_ctrl #(
  parameter int CNT_W         = 24,
  parameter int SETTLE_CYCLES = 4,
  parameter int FLUSH_CYCLES  = 8,
  parameter int RESET_CYCLES  = 16,
  parameter int TIMEOUT       = 65535,
  parameter bit BIT_SWAP      = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             abort,
  input  logic [31:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [31:0]      icap_i,
  output logic             icap_csib,
  output logic             icap_rdwrb,
  output logic             rp_decouple,
  output logic             rp_reset,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);
  typedef enum logic [2:0] {
    S_IDLE, S_DECOUPLE, S_LOAD, S_FLUSH, S_RM_RESET, S_RECOUPLE, S_FAIL
  } state_t;
  state_t           r_state, w_state;
  logic [31:0]      r_timer, w_timer;
  logic [CNT_W-1:0] r_lat, w_lat, r_wl, w_wl;
  logic [31:0]      r_icap, w_icap, w_swap;
  logic             r_ready, w_ready, r_csib, w_csib, r_rdwrb, w_rdwrb;
  logic             r_dec, w_dec, r_rst, w_rst, r_busy, w_busy, r_done, w_done, r_err, w_err;
  logic             w_xfer;
  // Bit b of a byte maps to bit 7-b of the same byte, i.e. index b^7.
  for (genvar b = 0; b < 32; b++) begin : g_swap
    assign w_swap[b] = s_data[BIT_SWAP ? (b ^ 7) : b];
  end
  // abort must block a coincident handshake, so it gates s_ready combinationally.
  assign s_ready      = r_ready & ~abort;
  assign w_xfer       = s_valid & s_ready;
  assign icap_i       = r_icap;
  assign icap_csib    = r_csib;
  assign icap_rdwrb   = r_rdwrb;
  assign rp_decouple  = r_dec;
  assign rp_reset     = r_rst;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_err;
  assign words_loaded = r_wl;
  always_comb begin
    w_state = r_state;
    w_timer = r_timer + 32'd1;
    w_lat   = r_lat;
    w_wl    = r_wl;
    w_ready = 1'b0;
    w_icap  = r_icap;
    w_csib  = 1'b1;
    w_rdwrb = r_rdwrb;
    w_dec   = r_dec;
    w_rst   = r_rst;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_err   = r_err;
    case (r_state)
      S_IDLE: begin
        w_timer = '0;
        if (start && word_count != '0) begin
          w_state = S_DECOUPLE;
          w_lat   = word_count;
          w_wl    = '0;
          w_err   = 1'b0;
          w_dec   = 1'b1;
          w_rdwrb = 1'b0;
          w_busy  = 1'b1;
        end else if (start) begin
          w_err = 1'b1;
        end
      end
      S_DECOUPLE: begin
        if (abort) begin
          w_state = S_FAIL;
          w_timer = '0;
          w_err   = 1'b1;
          w_rst   = 1'b1;
        end else if (r_timer == 32'(SETTLE_CYCLES - 1)) begin
          w_state = S_LOAD;
          w_timer = '0;
          w_ready = 1'b1;
        end
      end
      S_LOAD: begin
        if (abort || (!s_valid && r_timer == 32'(TIMEOUT - 1))) begin
          w_state = S_FAIL;
          w_timer = '0;
          w_err   = 1'b1;
          w_rst   = 1'b1;
        end else begin
          w_wl    = (w_xfer && r_wl != r_lat) ? r_wl + 1'b1 : r_wl;
          w_ready = w_wl < r_lat;
          w_csib  = ~w_xfer;
          w_icap  = w_xfer ? w_swap : r_icap;
          w_timer = s_valid ? '0 : r_timer + 32'd1;
          if (w_xfer && w_wl == r_lat) begin
            w_state = S_FLUSH;
            w_timer = '0;
          end
        end
      end
      S_FLUSH: begin
        if (abort) begin
          w_state = S_FAIL;
          w_timer = '0;
          w_err   = 1'b1;
          w_rst   = 1'b1;
        end else if (r_timer == 32'(FLUSH_CYCLES - 1)) begin
          w_state = S_RM_RESET;
          w_timer = '0;
          w_rst   = 1'b1;
        end
      end
      S_RM_RESET: begin
        if (r_timer == 32'(RESET_CYCLES - 1)) begin
          w_state = S_RECOUPLE;
          w_rst   = 1'b0;
          w_dec   = 1'b0;
          w_done  = 1'b1;
        end
      end
      S_RECOUPLE: begin
        w_state = S_IDLE;
        w_timer = '0;
        w_busy  = 1'b0;
        w_rdwrb = 1'b1;
      end
      S_FAIL: begin
        if (r_timer == 32'(RESET_CYCLES - 1)) begin
          w_state = S_IDLE;
          w_timer = '0;
          w_rst   = 1'b0;
          w_busy  = 1'b0;
          w_rdwrb = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_lat   <= '0;
      r_wl    <= '0;
      r_ready <= 1'b0;
      r_icap  <= '0;
      r_csib  <= 1'b1;
      r_rdwrb <= 1'b1;
      r_dec   <= 1'b0;
      r_rst   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_timer <= w_timer;
      r_lat   <= w_lat;
      r_wl    <= w_wl;
      r_ready <= w_ready;
      r_icap  <= w_icap;
      r_csib  <= w_csib;
      r_rdwrb <= w_rdwrb;
      r_dec   <= w_dec;
      r_rst   <= w_rst;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end
endmodule

// File: tb/tb_pr_reconfig_ctrl.sv
// tb_pr_reconfig_ctrl: scoreboard bench; ICAP writes and done pulses are checked by a negedge monitor.
module tb_pr_reconfig_ctrl;
  localparam int CW = 24;
  logic          CLK = 1'b0, RST = 1'b1, start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [CW-1:0] word_count = '0;
  logic [31:0]   s_data = '0;
  logic          s_ready, icap_csib, icap_rdwrb, rp_decouple, rp_reset, busy, done, error;
  logic [31:0]   icap_i;
  logic [CW-1:0] words_loaded;
  always #5 CLK = ~CLK;
  pr_reconfig_ctrl #(.CNT_W(CW), .TIMEOUT(10)) dut (
    .CLK(CLK), .RST(RST), .start(start), .word_count(word_count), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .icap_i(icap_i),
    .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .rp_decouple(rp_decouple),
    .rp_reset(rp_reset), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );
  typedef struct {int wl; int lat;} done_t;
  int total = 0, bad = 0, cyc = 0, t_start = 0;
  int csib_lo = 0, run = 0, max_run = 0, rst_hi = 0, done_cnt = 0, got = 0, k = 0;
  logic [31:0] exp_icap[$], src[$], exp_tab[$];
  done_t exp_done[$];
  logic [31:0] e;
  done_t d;
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add_done(input int wl, input int lat);
    done_t t;
    t.wl = wl;
    t.lat = lat;
    exp_done.push_back(t);
  endtask
  always @(posedge CLK) cyc++;
  always @(negedge CLK) begin
    if (!icap_csib) begin
      csib_lo++;
      run++;
      if (run > max_run) max_run = run;
      if (exp_icap.size() == 0) begin
        total++; bad++;
        $display("FAIL icap_unexpected: got write %0h expected none", icap_i);
      end else begin
        e = exp_icap.pop_front();
        chk("icap_i", icap_i, e);
      end
    end else run = 0;
    if (rp_reset) rst_hi++;
    if (done) begin
      done_cnt++;
      if (exp_done.size() == 0) begin
        total++; bad++;
        $display("FAIL done_unexpected: got done=1 expected none");
      end else begin
        d = exp_done.pop_front();
        chk("done_words_loaded", words_loaded, d.wl);
        chk("done_error", error, 0);
        if (d.lat >= 0) chk("done_latency", cyc - t_start, d.lat);
      end
    end
  end
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic clr;
    csib_lo = 0; max_run = 0; rst_hi = 0; done_cnt = 0;
  endtask
  task automatic go(input int wc);
    word_count = CW'(wc);
    start = 1'b1;
    t_start = cyc;
    tick;
    start = 1'b0;
  endtask
  task automatic feed(input int n, input bit gapped, input int stop_after, input int abort_idx,
                      input int restart_idx, output int taken);
    int i = 0, c = 0;
    while (i < n && i < stop_after && c < 200) begin
      s_valid = gapped ? (c % 3 == 0) : 1'b1;
      s_data = src[i];
      abort = (i == abort_idx);
      if (i == restart_idx) begin
        start = 1'b1;
        word_count = CW'(7);
      end
      @(negedge CLK);
      if (s_valid && s_ready) begin
        exp_icap.push_back(exp_tab[i]);
        i++;
      end
      tick;
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        break;
      end
      c++;
    end
    s_valid = 1'b0;
    taken = i;
  endtask
  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      tick;
      n++;
    end
    chk("idle_reached_busy", busy, 0);
  endtask
  task automatic chk_reset;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_icap_i", icap_i, 0);
    chk("rst_csib", icap_csib, 1);
    chk("rst_rdwrb", icap_rdwrb, 1);
    chk("rst_decouple", rp_decouple, 0);
    chk("rst_rp_reset", rp_reset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words_loaded", words_loaded, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) tick;
    chk_reset;
    RST = 1'b0;
    tick;
    // normal load, continuous source
    src = '{32'h01234567, 32'h89ABCDEF, 32'hAA995566};
    exp_tab = '{32'h80C4A2E6, 32'h91D5B3F7, 32'h5599AA66};
    clr;
    add_done(3, 32);
    go(3);
    chk("t1_decouple", rp_decouple, 1);
    chk("t1_busy", busy, 1);
    chk("t1_rdwrb", icap_rdwrb, 0);
    feed(3, 1'b0, 99, -1, -1, got);
    chk("t1_taken", got, 3);
    chk("t1_decouple_mid", rp_decouple, 1);
    wait_idle(100);
    chk("t1_csib_low", csib_lo, 3);
    chk("t1_csib_run", max_run, 3);
    chk("t1_rp_reset_cycles", rst_hi, 16);
    chk("t1_done_count", done_cnt, 1);
    chk("t1_decouple_after", rp_decouple, 0);
    chk("t1_words_loaded", words_loaded, 3);
    // gapped source
    src = '{32'h00000001, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h80402010};
    exp_tab = '{32'h00000080, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'h01020408};
    clr;
    add_done(4, -1);
    go(4);
    feed(4, 1'b1, 99, -1, -1, got);
    chk("t2_taken", got, 4);
    wait_idle(100);
    chk("t2_csib_low", csib_lo, 4);
    chk("t2_csib_run", max_run, 1);
    chk("t2_done_count", done_cnt, 1);
    chk("t2_error", error, 0);
    // timeout after two words
    src = '{32'h00000002, 32'h12345678, 32'h0, 32'h0, 32'h0};
    exp_tab = '{32'h00000040, 32'h482C6A1E, 32'h0, 32'h0, 32'h0};
    clr;
    go(5);
    feed(5, 1'b0, 2, -1, -1, got);
    chk("t3_taken", got, 2);
    k = 0;
    while (!rp_reset && k < 50) begin
      tick;
      k++;
    end
    chk("t3_timeout_cycles", k, 10);
    chk("t3_error", error, 1);
    chk("t3_words_loaded", words_loaded, 2);
    wait_idle(100);
    chk("t3_rp_reset_cycles", rst_hi, 16);
    chk("t3_done_count", done_cnt, 0);
    chk("t3_decouple_kept", rp_decouple, 1);
    chk("t3_error_sticky", error, 1);
    // abort coincident with word 2
    src = '{32'h000000FF, 32'h12345678, 32'h0};
    exp_tab = '{32'h000000FF, 32'h482C6A1E, 32'h0};
    clr;
    go(3);
    feed(3, 1'b0, 99, 1, -1, got);
    chk("t4_taken", got, 1);
    chk("t4_error", error, 1);
    chk("t4_rp_reset", rp_reset, 1);
    chk("t4_busy", busy, 1);
    wait_idle(100);
    chk("t4_csib_low", csib_lo, 1);
    chk("t4_done_count", done_cnt, 0);
    chk("t4_decouple_kept", rp_decouple, 1);
    src = '{32'h00000010};
    exp_tab = '{32'h00000008};
    clr;
    add_done(1, -1);
    go(1);
    chk("t4b_error_cleared", error, 0);
    feed(1, 1'b0, 99, -1, -1, got);
    wait_idle(100);
    chk("t4b_done_count", done_cnt, 1);
    chk("t4b_decouple", rp_decouple, 0);
    chk("t4b_csib_low", csib_lo, 1);
    // zero word count, then a restart during LOAD
    clr;
    go(0);
    chk("t5_error", error, 1);
    chk("t5_busy", busy, 0);
    chk("t5_decouple", rp_decouple, 0);
    repeat (3) tick;
    chk("t5_busy_later", busy, 0);
    chk("t5_csib_low", csib_lo, 0);
    src = '{32'hC0000000, 32'h00000003};
    exp_tab = '{32'h03000000, 32'h000000C0};
    add_done(2, -1);
    go(2);
    feed(2, 1'b0, 99, -1, 1, got);
    wait_idle(100);
    chk("t5b_done_count", done_cnt, 1);
    chk("t5b_words_loaded", words_loaded, 2);
    chk("t5b_csib_low", csib_lo, 2);
    chk("t5b_error", error, 0);
    // reset in the middle of LOAD
    src = '{32'hDEADBEEF, 32'h01010101, 32'h0, 32'h0};
    exp_tab = '{32'h7BB57DF7, 32'h80808080, 32'h0, 32'h0};
    clr;
    go(4);
    feed(4, 1'b0, 2, -1, -1, got);
    chk("t6_taken", got, 2);
    chk("t6_busy_before", busy, 1);
    RST = 1'b1;
    tick;
    chk_reset;
    RST = 1'b0;
    repeat (3) tick;
    chk("t6_done_count", done_cnt, 0);
    chk("end_icap_queue", exp_icap.size(), 0);
    chk("end_done_queue", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pr_reconfig_ctrl.md
Name: pr_reconfig_ctrl

Overview:
Sequences one partial-reconfiguration load of the PL reconfigurable partition. It accepts a start command and a word count from the PS-side control bus, then asserts decouple on the partition. It streams bitstream words from a valid/ready source into the ICAP primitive, pulses reset to the new module, and releases decouple. It sits in the PL top level, between the bus/DMA word stream and ICAP plus the partition boundary.

Parameters:
CNT_W, 24, width of word_count and words_loaded
SETTLE_CYCLES, 4, cycles decouple is held before the first ICAP write (min 1)
FLUSH_CYCLES, 8, idle cycles after the last ICAP write before RM reset (min 1)
RESET_CYCLES, 16, cycles rp_reset is held high (min 1)
TIMEOUT, 65535, max consecutive LOAD cycles without s_valid before error (min 1)
BIT_SWAP, 1, 1 = reverse bit order within each byte of s_data before ICAP; 0 = pass through

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
start  in  1  one-cycle load request; sampled only in IDLE
word_count  in  CNT_W  number of 32-bit words to load; sampled with start
abort  in  1  cancel the load; honoured in DECOUPLE, LOAD and FLUSH
s_data  in  32  bitstream word
s_valid  in  1  s_data valid
s_ready  out  1  controller accepts a word
icap_i  out  32  ICAP data input
icap_csib  out  1  ICAP chip select, active-low
icap_rdwrb  out  1  ICAP direction, 0 = write
rp_decouple  out  1  isolates the reconfigurable partition
rp_reset  out  1  reset to the reconfigurable module, active-high
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on successful completion
error  out  1  sticky; cleared on the next accepted start
words_loaded  out  CNT_W  words written to ICAP in the current or last load

Behaviour:
- All outputs are registered. Reset values: s_ready=0, icap_i=0, icap_csib=1, icap_rdwrb=1, rp_decouple=0, rp_reset=0, busy=0, done=0, error=0, words_loaded=0. RST mid-load forces these values and IDLE immediately; no flush is performed.
- States: IDLE, DECOUPLE, LOAD, FLUSH, RM_RESET, RECOUPLE, FAIL.
- IDLE, start=1, word_count!=0: latch word_count, clear error and words_loaded, set rp_decouple=1, go to DECOUPLE.
- IDLE, start=1, word_count==0: set error=1 and stay in IDLE; outputs are otherwise unchanged.
- start outside IDLE is ignored.
- DECOUPLE: lasts SETTLE_CYCLES cycles, then goes to LOAD. icap_rdwrb=0 from DECOUPLE entry until return to IDLE.
- LOAD: s_ready=1 while the count is below the latched value.
  - Handshake: a word transfers in cycle N when s_valid&s_ready. In cycle N+1, icap_i = swap(s_data), icap_csib=0, and words_loaded increments.
  - icap_csib=1 in any cycle following no transfer; back-to-back transfers give continuous csib=0.
  - s_ready drops in the cycle after the final transfer. Go to FLUSH once the last word has been presented.
  - The idle counter resets on each transfer. TIMEOUT consecutive cycles with s_valid=0 -> FAIL.
- FLUSH: icap_csib=1 for FLUSH_CYCLES cycles, then go to RM_RESET.
- RM_RESET: rp_reset=1 for RESET_CYCLES cycles, then go to RECOUPLE.
- RECOUPLE (1 cycle): rp_reset=0, rp_decouple=0, done=1, then go to IDLE.
- abort in DECOUPLE/LOAD/FLUSH, or timeout -> FAIL.
  - If abort and a transfer occur in the same cycle, abort wins: the word is not accepted (s_ready is forced 0 combinationally by abort) and csib stays 1.
- FAIL: icap_csib=1, s_ready=0, error=1, rp_reset=1 for RESET_CYCLES cycles, then go to IDLE with rp_reset=0.
  - rp_decouple stays 1 after a failure until a later load completes successfully.
  - done is not pulsed.
- swap: when BIT_SWAP=1, output bit 8k+i = input bit 8k+(7-i) for each byte k.
- The words_loaded counter saturates at the latched count and never wraps.
- Minimum cycles from start to done with continuous s_valid: 1 + SETTLE_CYCLES + word_count + FLUSH_CYCLES + RESET_CYCLES + 1 (±1 for the csib pipeline; the bench asserts the exact value produced by the RTL, fixed at design review).

Test Plan:
- Normal load, defaults, word_count=3, s_valid held high, data 0x01234567/0x89ABCDEF/0xAA995566 -> csib low for exactly 3 consecutive cycles; icap_i = 0x80C4A2E6, 0x91D5B3F7, 0x5599AA66; decouple high throughout; rp_reset high 16 cycles; single done pulse; decouple low after; words_loaded=3.
- Gapped source, word_count=4, s_valid toggling 1,0,0,1,... -> csib low only in the cycle after each transfer; 4 csib-low cycles total; done asserted; error=0.
- Timeout, TIMEOUT=10, word_count=5, stall after 2 words -> FAIL entered on the 10th idle cycle; error=1; rp_reset high 16 cycles; decouple stays 1; no done; words_loaded=2.
- Abort coincident with a transfer on word 2 -> word 2 is not written (csib stays 1); FAIL; error=1. A following start with word_count=1 completes and clears error and decouple.
- start with word_count=0 -> error=1, busy stays 0, no csib activity. A second start during LOAD is ignored.
- RST asserted during LOAD -> next cycle all outputs at reset values: csib=1, decouple=0, state IDLE.
